// File: rtl/lzw_dec_sched.sv
// lzw_dec_sched: two-channel frame scheduler in front of the LZW decoder.
// Grants one compressed word stream per frame (round-robin across frames),
// passes words straight through to the decoder, tags decoded bytes with the
// owning channel, reports per-frame byte counts, and clears the decoder
// dictionary between frames.
//
// Optional build macro: LZW_SCHED_WDOG_EN adds a stall watchdog in STREAM
// and a FLUSH state that discards the rest of an aborted frame.
//
// state  | meaning
// CLEAR  | o_dec_rst held high for CLR_CYC cycles (dictionary clear)
// IDLE   | waiting for a request, picks the channel for the next frame
// STREAM | granted channel is passed through to the decoder
// DRAIN  | no words forwarded, waiting for DRAIN_CYC-1 quiet cycles
// FLUSH  | (watchdog build) discards words until the frame's last word

module lzw_dec_sched #(
  parameter int CLR_CYC   = 2,
  parameter int DRAIN_CYC = 8,
  parameter int CNT_W     = 16,
  parameter int WDOG_CYC  = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [15:0]      i_s0_data,
  input  logic             i_s0_valid,
  input  logic             i_s0_last,
  output logic             o_s0_ready,
  input  logic [15:0]      i_s1_data,
  input  logic             i_s1_valid,
  input  logic             i_s1_last,
  output logic             o_s1_ready,
  output logic [15:0]      o_dec_data,
  output logic             o_dec_valid,
  output logic             o_dec_last,
  input  logic             i_dec_ready,
  output logic             o_dec_rst,
  input  logic [7:0]       i_dec_byte,
  input  logic             i_dec_byte_valid,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  output logic             o_byte_ch,
  output logic             o_frame_done,
  output logic             o_frame_ch,
  output logic [CNT_W-1:0] o_frame_bytes,
  output logic             o_busy,
  output logic             o_err
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int Q_W   = $clog2(DRAIN_CYC);

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3
`ifdef LZW_SCHED_WDOG_EN
    ,ST_FLUSH = 3'd4
`endif
  } state_t;

  state_t           state, state_nxt;
  logic             grant;        // doubles as the last-served pointer
  logic [CLR_W-1:0] clr_cnt;
  logic [Q_W-1:0]   quiet_cnt;
  logic [CNT_W-1:0] byte_cnt;

  logic [15:0] g_data;
  logic        g_valid, g_last;
  logic        accept, quiet, clr_done, drain_done, pick, start, in_frame;
  logic        wdog_trip;

  assign g_data     = grant ? i_s1_data  : i_s0_data;
  assign g_valid    = grant ? i_s1_valid : i_s0_valid;
  assign g_last     = grant ? i_s1_last  : i_s0_last;
  assign accept     = (state == ST_STREAM) && g_valid && i_dec_ready;
  assign quiet      = i_dec_ready && !i_dec_byte_valid;
  assign clr_done   = (clr_cnt == CLR_W'(CLR_CYC - 1));
  // Counter reaches DRAIN_CYC-1 on this edge: frame is declared done.
  assign drain_done = (state == ST_DRAIN) && quiet && (quiet_cnt == Q_W'(DRAIN_CYC - 2));
  // With both requesting, serve the channel that did not own the last frame.
  assign pick       = (i_s0_valid && i_s1_valid) ? ~grant : i_s1_valid;
  assign start      = (state == ST_IDLE) && (state_nxt == ST_STREAM);
  assign in_frame   = (state == ST_STREAM) || (state == ST_DRAIN);
  assign o_busy     = (state != ST_IDLE);

`ifdef LZW_SCHED_WDOG_EN
  localparam int S_W = $clog2(WDOG_CYC + 1);
  logic [S_W-1:0] stall_cnt;
  assign wdog_trip = (state == ST_STREAM) && !accept && (stall_cnt == S_W'(WDOG_CYC - 1));

  // Stall counter: cycles in STREAM without an accepted word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
      o_err     <= 1'b0;
    end else begin
      o_err <= wdog_trip;
      if (state != ST_STREAM || accept || wdog_trip) stall_cnt <= '0;
      else                                           stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYC;
  assign wdog_trip   = 1'b0;
  assign o_err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR:  if (clr_done) state_nxt = ST_IDLE;
      ST_IDLE:   if (i_s0_valid || i_s1_valid) state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (accept && g_last) state_nxt = ST_DRAIN;
`ifdef LZW_SCHED_WDOG_EN
        else if (wdog_trip)   state_nxt = ST_FLUSH;
`endif
      end
      ST_DRAIN:  if (drain_done) state_nxt = ST_CLEAR;
`ifdef LZW_SCHED_WDOG_EN
      ST_FLUSH:  if (g_valid && g_last) state_nxt = ST_CLEAR;
`endif
      default:   state_nxt = ST_CLEAR;
    endcase
  end

  // Word-path outputs: combinational pass-through of the granted channel.
  always_comb begin
    o_s0_ready  = 1'b0;
    o_s1_ready  = 1'b0;
    o_dec_data  = '0;
    o_dec_valid = 1'b0;
    o_dec_last  = 1'b0;
    case (state)
      ST_STREAM: begin
        o_dec_data  = g_data;
        o_dec_valid = g_valid;
        o_dec_last  = g_last;
        if (grant) o_s1_ready = i_dec_ready;
        else       o_s0_ready = i_dec_ready;
      end
`ifdef LZW_SCHED_WDOG_EN
      ST_FLUSH: begin
        if (grant) o_s1_ready = 1'b1;
        else       o_s0_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Grant, clear timer, quiet timer and decoder reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant     <= 1'b1;
      clr_cnt   <= '0;
      quiet_cnt <= '0;
      o_dec_rst <= 1'b1;
    end else begin
      if (start) grant <= pick;
      if (state == ST_CLEAR && !clr_done) clr_cnt <= clr_cnt + 1'b1;
      else                                clr_cnt <= '0;
      if (state == ST_DRAIN && quiet && !drain_done) quiet_cnt <= quiet_cnt + 1'b1;
      else                                           quiet_cnt <= '0;
      o_dec_rst <= (state_nxt == ST_CLEAR);
    end
  end

  // Byte path, saturating frame byte counter and frame-done report.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt      <= '0;
      o_byte        <= '0;
      o_byte_valid  <= 1'b0;
      o_byte_ch     <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_ch    <= 1'b0;
      o_frame_bytes <= '0;
    end else begin
      o_byte_valid <= in_frame && i_dec_byte_valid;
      if (in_frame && i_dec_byte_valid) begin
        o_byte    <= i_dec_byte;
        o_byte_ch <= grant;
      end
      if (start)
        byte_cnt <= '0;
      else if (in_frame && i_dec_byte_valid && byte_cnt != {CNT_W{1'b1}})
        byte_cnt <= byte_cnt + 1'b1;
      o_frame_done <= drain_done;
      if (drain_done) begin
        o_frame_ch    <= grant;
        o_frame_bytes <= byte_cnt;
      end
    end
  end

endmodule
